// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller state encoding, MISR width and the
// feedback taps common to the pattern LFSR and the response MISR.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int MISR_W = 9;
  localparam int TAP_A  = 4;
  localparam int TAP_B  = 1;

endpackage

// File: rtl/bist_misr_ctrl_if.sv
// Control/status bundle between a BIST sequencer (master) and the MISR
// controller (slave).
interface bist_misr_ctrl_if
  import bist_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_patterns;
  logic [MISR_W-1:0] golden;
  logic [MISR_W-1:0] resp_in;
  logic              lfsr_init;
  logic              lfsr_en;
  logic              busy;
  logic              done;
  logic              pass;
  logic [MISR_W-1:0] signature;

  modport master (
    output start, abort, num_patterns, golden, resp_in,
    input  lfsr_init, lfsr_en, busy, done, pass, signature
  );

  modport slave (
    input  start, abort, num_patterns, golden, resp_in,
    output lfsr_init, lfsr_en, busy, done, pass, signature
  );

endinterface

// File: rtl/misr_9b.sv
// Multiple-input signature register: shift-right compaction of a response
// word using the same feedback taps as the pattern LFSR.
module misr_9b
  import bist_pkg::*;
#(
  parameter logic [MISR_W-1:0] RESET_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [MISR_W-1:0] seed_i,
  input  logic              en_i,
  input  logic [MISR_W-1:0] d_i,
  output logic [MISR_W-1:0] q_o
);

  logic [MISR_W-1:0] q_q;
  logic [MISR_W-1:0] q_d;

  // Seed load wins over compaction so a run always starts from a known value.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = seed_i;
    end else if (en_i) begin
      q_d[MISR_W-2:0] = q_q[MISR_W-1:1] ^ d_i[MISR_W-2:0];
      q_d[MISR_W-1]   = q_q[TAP_A] ^ q_q[TAP_B] ^ d_i[MISR_W-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/bist_misr_ctrl.sv
// BIST run sequencer: seeds and enables the pattern LFSR for num_patterns
// cycles, compacts the CUT response in a MISR and checks it against golden.
module bist_misr_ctrl
  import bist_pkg::*;
#(
  parameter int                CNT_W     = 16,
  parameter logic [MISR_W-1:0] MISR_SEED = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  bist_misr_ctrl_if.slave   bus
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              lfsr_init_q;
  logic              lfsr_en_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [MISR_W-1:0] signature;
  logic              misrLoad;
  logic              misrEn;

  // An abort edge neither reseeds nor compacts, leaving the partial signature.
  assign misrLoad = (state_q == SEED) && !bus.abort;
  assign misrEn   = (state_q == RUN)  && !bus.abort;

  misr_9b #(
    .RESET_VAL (MISR_SEED)
  ) u_misr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (misrLoad),
    .seed_i (MISR_SEED),
    .en_i   (misrEn),
    .d_i    (bus.resp_in),
    .q_o    (signature)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lfsr_init_q <= 1'b0;
      lfsr_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= SEED;
            lfsr_init_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        SEED: begin
          lfsr_init_q <= 1'b0;
          pass_q      <= 1'b0;
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= '0;
            if (bus.num_patterns == '0) begin
              state_q <= CHECK;
            end else begin
              state_q   <= RUN;
              lfsr_en_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state_q   <= IDLE;
            lfsr_en_q <= 1'b0;
            busy_q    <= 1'b0;
            pass_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            // Leaving on num_patterns-1 gives exactly num_patterns compactions.
            if (cnt_q == bus.num_patterns - CNT_W'(1)) begin
              state_q   <= CHECK;
              lfsr_en_q <= 1'b0;
            end
          end
        end
        CHECK: begin
          busy_q <= 1'b0;
          if (bus.abort) begin
            state_q <= IDLE;
            pass_q  <= 1'b0;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (signature == bus.golden);
          end
        end
        DONE: begin
          if (!bus.start) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.lfsr_init = lfsr_init_q;
  assign bus.lfsr_en   = lfsr_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = signature;

endmodule
